// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and elaboration helpers for the parametrised sync FIFO.
//   DEF_DATA_W / DEF_DEPTH : default word width and entry count
//   clog2()                : address width for a given depth (minimum 1)
//   is_pow2()              : depth legality check (pointers wrap by natural rollover)
package fifo_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 8;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// fifo_ram_2p: storage array for sync_fifo_param, one synchronous write port and one read port.
// Configuration macro: SYNC_FIFO_FWFT_EN
//   undefined : read port registered, rd_data loads mem[rd_addr] when rd_en is high
//   defined   : read port combinational, rd_data = mem[rd_addr]
// Ports:
//   clk, rst_n        clock / async active-low reset (read register only, array is not reset)
//   wr_en, wr_addr, wr_data   write port
//   rd_en, rd_addr, rd_data   read port
module fifo_ram_2p
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [clog2(DEPTH)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [clog2(DEPTH)-1:0]  rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word falls through; read strobe and reset are not needed here.
    logic unused_rd;
    assign unused_rd = rd_en ^ rst_n;
    assign rd_data   = mem[rd_addr];
`else
    logic [DATA_W-1:0] rd_data_q;

    // A same-edge write to rd_addr is not seen: the old word is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with almost-full/almost-empty flags,
// sticky overflow/underflow errors and a synchronous flush.
// Configuration macro: SYNC_FIFO_FWFT_EN (defined = first-word fall-through read port,
// undefined = registered read with a one-cycle rd_valid pulse per accepted read).
// Ports:
//   clk, rst_n, clr          clock, async active-low reset, synchronous flush (highest priority)
//   wr_en, wr_data           write request and data
//   rd_en, rd_data, rd_valid read request (pop), read data, read data valid
//   full, empty              count==DEPTH / count==0
//   almost_full/_empty       count>=AF_LEVEL / count<=AE_LEVEL
//   count                    occupancy 0..DEPTH
//   overflow, underflow      sticky error flags, cleared by rst_n or clr
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned AF_LEVEL = 6,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned ADDR_W = clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam bit PARAMS_OK = is_pow2(DEPTH) && (DEPTH >= 2) && (DATA_W >= 1) &&
                               (AF_LEVEL >= 1) && (AF_LEVEL <= DEPTH) && (AE_LEVEL < DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              rd_acc, wr_acc;

    // Flags decode the registered count, so they move the cycle after the access.
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        // clr wins over both requests; accesses in that cycle are dropped silently.
        rd_acc = rd_en & ~empty & ~clr;
        // A write on full is legal only alongside an accepted read.
        wr_acc = wr_en & (~full | rd_acc) & ~clr;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
            if (wr_en && !wr_acc) begin
                overflow_d = 1'b1;
            end
            if (rd_en && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_valid = ~empty;
`else
    logic rd_valid_q;

    // rd_acc is already low during clr, which also clears the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
        end
    end

    assign rd_valid = rd_valid_q;
`endif

    fifo_ram_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    params_legal : assert property (@(posedge clk) PARAMS_OK);

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: randomized and directed bench for sync_fifo_param (standard read mode),
// checked against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int DP = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full, empty, almost_full, almost_empty;
    logic [3:0]    count;
    logic          overflow, underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rd_data;
    bit            m_rv, m_ov, m_un;

    sync_fifo_param #(
        .DATA_W   (DW),
        .DEPTH    (DP),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        int n;
        n = mq.size();
        check_eq({tag, ".count"},        32'(count),        32'(n));
        check_eq({tag, ".full"},         32'(full),         32'(n == DP));
        check_eq({tag, ".empty"},        32'(empty),        32'(n == 0));
        check_eq({tag, ".almost_full"},  32'(almost_full),  32'(n >= AF));
        check_eq({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
        check_eq({tag, ".overflow"},     32'(overflow),     32'(m_ov));
        check_eq({tag, ".underflow"},    32'(underflow),    32'(m_un));
        check_eq({tag, ".rd_valid"},     32'(rd_valid),     32'(m_rv));
        check_eq({tag, ".rd_data"},      32'(rd_data),      32'(m_rd_data));
    endtask

    task automatic model_reset();
        mq.delete();
        m_rd_data = '0;
        m_rv = 1'b0;
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic step(input string tag, input bit w, input logic [DW-1:0] d, input bit r,
                        input bit c);
        bit was_empty, was_full, racc, wacc;
        clr     = c;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
        if (c) begin
            mq.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
            m_rv = 1'b0;
        end else begin
            was_empty = (mq.size() == 0);
            was_full  = (mq.size() == DP);
            racc = r && !was_empty;
            wacc = w && (!was_full || racc);
            m_rv = racc;
            if (racc) m_rd_data = mq.pop_front();
            if (wacc) mq.push_back(d);
            if (w && !wacc) m_ov = 1'b1;
            if (r && was_empty) m_un = 1'b1;
        end
        check_outputs(tag);
    endtask

    initial begin
        int p_wr, p_rd;
        rst_n   = 1'b0;
        clr     = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        model_reset();
        #2;
        check_outputs("reset");
        #10;
        rst_n = 1'b1;

        // Fill then drain
        for (int i = 1; i <= 8; i++) step("fill", 1'b1, DW'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
        step("idle1", 1'b0, '0, 1'b0, 1'b0);

        // Wrap-around
        for (int i = 0; i < 5; i++) step("wrap_w5", 1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step("wrap_r5", 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step("wrap_w8", 1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("wrap_r8", 1'b0, '0, 1'b1, 1'b0);

        // Full + simultaneous, then overflow on full
        for (int i = 0; i < 8; i++) step("full_fill", 1'b1, DW'(8'h30 + i), 1'b0, 1'b0);
        step("full_rw", 1'b1, 8'hAA, 1'b1, 1'b0);
        step("full_ovf", 1'b1, 8'hEE, 1'b0, 1'b0);
        step("ovf_hold", 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("full_drain", 1'b0, '0, 1'b1, 1'b0);

        // Empty + simultaneous
        step("empty_rw", 1'b1, 8'h55, 1'b1, 1'b0);
        step("empty_rd55", 1'b0, '0, 1'b1, 1'b0);
        step("unf_hold", 1'b0, '0, 1'b0, 1'b0);

        // Flush with a write in the clr cycle
        for (int i = 0; i < 8; i++) step("clr_load", 1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
        step("clr_ovf", 1'b1, 8'h99, 1'b0, 1'b0);
        step("clr_wr", 1'b1, 8'h77, 1'b1, 1'b1);
        step("post_clr", 1'b0, '0, 1'b0, 1'b0);

        // Async reset mid-burst
        for (int i = 0; i < 3; i++) step("ar_load", 1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
        step("ar_rd", 1'b0, '0, 1'b1, 1'b0);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        #2;
        rst_n = 1'b1;
        step("after_rst_rd", 1'b0, '0, 1'b1, 1'b0);
        step("after_rst_clr", 1'b0, '0, 1'b0, 1'b1);

        // Randomized traffic with shifting read/write bias
        p_wr = 50;
        p_rd = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                p_wr = 20 + 30 * int'($urandom_range(0, 2));
                p_rd = 100 - p_wr;
            end
            step("rand",
                 $urandom_range(0, 99) < p_wr,
                 DW'($urandom),
                 $urandom_range(0, 99) < p_rd,
                 $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
